cv32e40p_apu_responder: RTL and testbench

// - Responder (unit) end of the core's APU interconnect: accepts req/gnt offloads from the EX-stage
//   APU dispatcher and returns results on rvalid/result/flags.
// - Hosts a fixed-latency integer pipeline (ADD/SUB/MUL/MULHU/MIN/MAX) and an optional iterative divider.
// - Results always return in grant order. The response channel has no backpressure.

---
 rtl/cv32e40p_apu_core_pkg.sv | 37 +++
 rtl/cv32e40p_apu_resp_div.sv | 115 +++++++++++
 rtl/cv32e40p_apu_responder.sv | 163 ++++++++++++++++
 tb/tb_cv32e40p_apu_responder.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cv32e40p_apu_core_pkg.sv
// -----------------------------------------------------------------------------
// cv32e40p_apu_core_pkg
// Shared types for the APU responder: opcode encoding, upstream flag bit
// positions and the divider FSM state encoding.
// -----------------------------------------------------------------------------
package cv32e40p_apu_core_pkg;

    localparam int APU_RESP_OP_W = 6;

    typedef enum logic [APU_RESP_OP_W-1:0] {
        APU_OP_ADD   = 6'd0,
        APU_OP_SUB   = 6'd1,
        APU_OP_MUL   = 6'd2,
        APU_OP_MULHU = 6'd3,
        APU_OP_MIN   = 6'd4,
        APU_OP_MAX   = 6'd5,
        APU_OP_DIV   = 6'd6,
        APU_OP_DIVU  = 6'd7,
        APU_OP_REM   = 6'd8,
        APU_OP_REMU  = 6'd9
    } apu_resp_op_e;

    // Bit positions inside apu_rflags_o
    localparam int APU_RFLAG_DZ  = 0;
    localparam int APU_RFLAG_ILL = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } apu_resp_div_state_e;

    function automatic logic is_div_op(apu_resp_op_e op);
        return op inside {APU_OP_DIV, APU_OP_DIVU, APU_OP_REM, APU_OP_REMU};
    endfunction

endpackage

// File: rtl/cv32e40p_apu_resp_div.sv
// -----------------------------------------------------------------------------
// cv32e40p_apu_resp_div
// Iterative restoring divider for DIV/DIVU/REM/REMU with RISC-V corner cases.
// start_i for one cycle in IDLE launches a divide; done_o pulses 33 cycles
// later with result_o/dz_o valid in that same cycle.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   start_i        launch (only honoured in IDLE)
//   op_i           DIV/DIVU/REM/REMU
//   dividend_i     operand 0, divisor_i operand 1 (sampled with start_i)
//   busy_o         FSM not IDLE
//   done_o         result valid (DONE state)
//   result_o       quotient or remainder after sign fix-up
//   dz_o           divisor was zero
// -----------------------------------------------------------------------------
module cv32e40p_apu_resp_div
    import cv32e40p_apu_core_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  apu_resp_op_e op_i,
    input  logic [31:0]  dividend_i,
    input  logic [31:0]  divisor_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [31:0]  result_o,
    output logic         dz_o
);

    apu_resp_div_state_e state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvsr_q, dvsr_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    logic        is_rem_q, is_rem_d;
    logic        dz_q, dz_d;

    logic        signed_op, neg_a, neg_b;
    logic [32:0] trial;

    assign signed_op = (op_i == APU_OP_DIV) || (op_i == APU_OP_REM);
    assign neg_a     = signed_op & dividend_i[31];
    assign neg_b     = signed_op & divisor_i[31];

    // Partial remainder with the next dividend bit shifted in, minus divisor
    assign trial = {rem_q, quo_q[31]} - {1'b0, dvsr_q};

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned; otherwise a latch is inferred.
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvsr_d    = dvsr_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        is_rem_d  = is_rem_q;
        dz_d      = dz_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d   = ST_DIV;
                    cnt_d     = 5'd31;
                    rem_d     = '0;
                    quo_d     = neg_a ? -dividend_i : dividend_i;
                    dvsr_d    = neg_b ? -divisor_i  : divisor_i;
                    dz_d      = (divisor_i == '0);
                    // x/0 must return all ones regardless of dividend sign
                    neg_quo_d = (neg_a ^ neg_b) & (divisor_i != '0);
                    neg_rem_d = neg_a;
                    is_rem_d  = (op_i == APU_OP_REM) || (op_i == APU_OP_REMU);
                end
            end
            ST_DIV: begin
                rem_d = trial[32] ? {rem_q[30:0], quo_q[31]} : trial[31:0];
                quo_d = {quo_q[30:0], ~trial[32]};
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd0) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every register samples pre-edge values regardless of block order.
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Datapath is always (re)loaded on start, so it carries no reset
    always_ff @(posedge clk) begin
        cnt_q     <= cnt_d;
        rem_q     <= rem_d;
        quo_q     <= quo_d;
        dvsr_q    <= dvsr_d;
        neg_quo_q <= neg_quo_d;
        neg_rem_q <= neg_rem_d;
        is_rem_q  <= is_rem_d;
        dz_q      <= dz_d;
    end

    assign busy_o   = (state_q != ST_IDLE);
    assign done_o   = (state_q == ST_DONE);
    assign dz_o     = dz_q;
    assign result_o = is_rem_q ? (neg_rem_q ? -rem_q : rem_q)
                               : (neg_quo_q ? -quo_q : quo_q);

endmodule

// File: rtl/cv32e40p_apu_responder.sv
// -----------------------------------------------------------------------------
// cv32e40p_apu_responder
// Responder end of the APU interconnect. Pipelined integer ops (ADD, SUB, MUL,
// MULHU, MIN, MAX) return after PIPE_DEPTH cycles; the optional divider
// returns after 33 cycles. Responses come back in grant order with no
// backpressure; result/flags are zero whenever rvalid is low.
// Configuration macro: CV32E40P_APU_RESP_DIV_EN
//   defined   - iterative divider present for DIV/DIVU/REM/REMU
//   undefined - those opcodes are illegal (result 0, ILL flag, pipelined)
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   apu_req_i/gnt_o   request / grant, transfer when both high
//   apu_operands_i    operands, [0] and [1] used
//   apu_op_i          opcode (apu_resp_op_e)
//   apu_flags_i       downstream flags, ignored
//   apu_rvalid_o      one-cycle result pulse per request
//   apu_result_o      result, apu_rflags_o: bit0 div-by-zero, bit1 illegal op
//   busy_o            any operation in flight
// -----------------------------------------------------------------------------
module cv32e40p_apu_responder
    import cv32e40p_apu_core_pkg::*;
#(
    parameter int APU_NARGS_CPU    = 3,
    parameter int APU_WOP_CPU      = 6,
    parameter int APU_NDSFLAGS_CPU = 15,
    parameter int APU_NUSFLAGS_CPU = 5,
    parameter int PIPE_DEPTH       = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        apu_req_i,
    output logic                        apu_gnt_o,
    input  logic [31:0]                 apu_operands_i [APU_NARGS_CPU],
    input  logic [APU_WOP_CPU-1:0]      apu_op_i,
    input  logic [APU_NDSFLAGS_CPU-1:0] apu_flags_i,
    output logic                        apu_rvalid_o,
    output logic [31:0]                 apu_result_o,
    output logic [APU_NUSFLAGS_CPU-1:0] apu_rflags_o,
    output logic                        busy_o
);

    localparam int LAST = PIPE_DEPTH - 1;

    apu_resp_op_e op;
    logic         op_hi_zero;
    logic         is_div;
    logic         xfer, pipe_xfer;
    logic [31:0]  op_a, op_b;
    logic [63:0]  prod;
    logic [31:0]  pipe_res;
    logic         pipe_ill;
    logic         pipe_hold;

    logic [PIPE_DEPTH-1:0] valid_q;
    logic [PIPE_DEPTH-1:0] ill_q;
    logic [31:0]           res_q [PIPE_DEPTH];

    logic        div_busy, div_done, div_dz;
    logic [31:0] div_res;
    logic        unused_inputs;

    assign op         = apu_resp_op_e'(apu_op_i[APU_RESP_OP_W-1:0]);
    assign op_hi_zero = ((apu_op_i >> APU_RESP_OP_W) == '0);
    assign op_a       = apu_operands_i[0];
    assign op_b       = apu_operands_i[1];
    assign prod       = {32'd0, op_a} * {32'd0, op_b};

    // Any entry that will still be in the pipeline next cycle; the last stage
    // drains this cycle, so a divide granted now cannot collide with it.
    always_comb begin
        pipe_hold = 1'b0;
        for (int i = 0; i < LAST; i++) pipe_hold |= valid_q[i];
    end

`ifdef CV32E40P_APU_RESP_DIV_EN
    assign is_div    = op_hi_zero & is_div_op(op);
    assign apu_gnt_o = apu_req_i & ~div_busy & (~is_div | ~pipe_hold);

    cv32e40p_apu_resp_div u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (xfer & is_div),
        .op_i       (op),
        .dividend_i (op_a),
        .divisor_i  (op_b),
        .busy_o     (div_busy),
        .done_o     (div_done),
        .result_o   (div_res),
        .dz_o       (div_dz)
    );
`else
    assign is_div    = 1'b0;
    assign apu_gnt_o = apu_req_i;
    assign div_busy  = 1'b0;
    assign div_done  = 1'b0;
    assign div_res   = '0;
    assign div_dz    = 1'b0;
`endif

    assign xfer      = apu_req_i & apu_gnt_o;
    assign pipe_xfer = xfer & ~is_div;

    // Result computed in the transfer cycle; stages only delay it
    always_comb begin
        pipe_res = '0;
        pipe_ill = 1'b0;
        case (op)
            APU_OP_ADD:   pipe_res = op_a + op_b;
            APU_OP_SUB:   pipe_res = op_a - op_b;
            APU_OP_MUL:   pipe_res = prod[31:0];
            APU_OP_MULHU: pipe_res = prod[63:32];
            APU_OP_MIN:   pipe_res = ($signed(op_a) < $signed(op_b)) ? op_a : op_b;
            APU_OP_MAX:   pipe_res = ($signed(op_a) > $signed(op_b)) ? op_a : op_b;
            default:      pipe_ill = 1'b1;
        endcase
        if (!op_hi_zero) begin
            pipe_res = '0;
            pipe_ill = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q[0] <= pipe_xfer;
            for (int i = 1; i < PIPE_DEPTH; i++) valid_q[i] <= valid_q[i-1];
        end
    end

    // NOTE: only the valid bits need reset; payload stages are qualified by
    // them, and leaving storage unreset keeps it out of the reset tree.
    always_ff @(posedge clk) begin
        res_q[0] <= pipe_res;
        ill_q[0] <= pipe_ill;
        for (int i = 1; i < PIPE_DEPTH; i++) begin
            res_q[i] <= res_q[i-1];
            ill_q[i] <= ill_q[i-1];
        end
    end

    // Grant gating guarantees the two sources never complete together
    always_comb begin
        apu_rvalid_o = valid_q[LAST] | div_done;
        apu_result_o = '0;
        apu_rflags_o = '0;
        if (valid_q[LAST]) begin
            apu_result_o                = res_q[LAST];
            apu_rflags_o[APU_RFLAG_ILL] = ill_q[LAST];
        end else if (div_done) begin
            apu_result_o               = div_res;
            apu_rflags_o[APU_RFLAG_DZ] = div_dz;
        end
    end

    assign busy_o = (|valid_q) | div_busy;

    always_comb begin
        unused_inputs = ^apu_flags_i;
        for (int i = 2; i < APU_NARGS_CPU; i++) unused_inputs ^= ^apu_operands_i[i];
    end

endmodule

// File: tb/tb_cv32e40p_apu_responder.sv
// -----------------------------------------------------------------------------
// tb_cv32e40p_apu_responder
// Self-checking bench: directed scenarios plus randomized traffic compared
// against an arithmetic reference model. Responses are logged with the cycle
// they appear in and matched in order against expected (cycle, result, flags).
// -----------------------------------------------------------------------------
module tb_cv32e40p_apu_responder;

    localparam int PIPE    = 2;
    localparam int DIV_LAT = 33;

    localparam logic [5:0] OP_ADD = 6'd0, OP_SUB = 6'd1, OP_MUL = 6'd2, OP_MULHU = 6'd3,
                           OP_MIN = 6'd4, OP_MAX = 6'd5, OP_DIV = 6'd6, OP_DIVU = 6'd7,
                           OP_REM = 6'd8, OP_REMU = 6'd9;

    typedef struct packed {
        logic [31:0] cyc;
        logic [31:0] res;
        logic [4:0]  flg;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        apu_req_i;
    logic        apu_gnt_o;
    logic [31:0] operands [3];
    logic [5:0]  apu_op_i;
    logic [14:0] apu_flags_i;
    logic        apu_rvalid_o;
    logic [31:0] apu_result_o;
    logic [4:0]  apu_rflags_o;
    logic        busy_o;

    resp_t       obs_q[$];
    resp_t       exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          idle_bad = 0;
    logic [31:0] cyc = '0;

    cv32e40p_apu_responder #(
        .APU_NARGS_CPU(3), .APU_WOP_CPU(6), .APU_NDSFLAGS_CPU(15),
        .APU_NUSFLAGS_CPU(5), .PIPE_DEPTH(PIPE)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .apu_req_i      (apu_req_i),
        .apu_gnt_o      (apu_gnt_o),
        .apu_operands_i (operands),
        .apu_op_i       (apu_op_i),
        .apu_flags_i    (apu_flags_i),
        .apu_rvalid_o   (apu_rvalid_o),
        .apu_result_o   (apu_result_o),
        .apu_rflags_o   (apu_rflags_o),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    // Log every response with its cycle; result/flags must be 0 otherwise
    always @(negedge clk) begin
        if (apu_rvalid_o === 1'b1) obs_q.push_back('{cyc, apu_result_o, apu_rflags_o});
        else if (apu_result_o !== 32'd0 || apu_rflags_o !== 5'd0) idle_bad++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    // Reference model: RISC-V arithmetic on wide integers
    function automatic void ref_model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] res, output logic [4:0] flg, output int lat);
        longint          sa, sb;
        longint unsigned ua, ub, p;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        p  = ua * ub;
        flg = 5'd0;
        lat = PIPE;
        res = 32'd0;
        case (op)
            OP_ADD:   res = a + b;
            OP_SUB:   res = a - b;
            OP_MUL:   res = p[31:0];
            OP_MULHU: res = p[63:32];
            OP_MIN:   res = (sa < sb) ? a : b;
            OP_MAX:   res = (sa > sb) ? a : b;
`ifdef CV32E40P_APU_RESP_DIV_EN
            OP_DIV, OP_REM: begin
                lat = DIV_LAT;
                if (b == 32'd0) begin
                    res = (op == OP_DIV) ? 32'hFFFF_FFFF : a;
                    flg = 5'd1;
                end else begin
                    res = (op == OP_DIV) ? 32'(sa / sb) : 32'(sa % sb);
                end
            end
            OP_DIVU, OP_REMU: begin
                lat = DIV_LAT;
                if (b == 32'd0) begin
                    res = (op == OP_DIVU) ? 32'hFFFF_FFFF : a;
                    flg = 5'd1;
                end else begin
                    res = (op == OP_DIVU) ? 32'(ua / ub) : 32'(ua % ub);
                end
            end
`endif
            default: flg = 5'b00010;
        endcase
    endfunction

    // Hold a request until granted; record the expected response
    task automatic send(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input logic [4:0] flg, input int lat, output int xfer);
        apu_req_i   = 1'b1;
        apu_op_i    = op;
        operands[0] = a;
        operands[1] = b;
        operands[2] = $urandom;
        apu_flags_i = 15'($urandom);
        xfer = -1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (apu_gnt_o === 1'b1) begin
                xfer = int'(cyc);
                break;
            end
        end
        @(posedge clk);
        #1;
        apu_req_i = 1'b0;
        total++;
        if (xfer < 0) begin
            bad++;
            $display("FAIL send_grant_timeout: op=%0h never granted within 100 cycles", op);
        end else begin
            exp_q.push_back('{32'(xfer + lat), res, flg});
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (busy_o === 1'b0) break;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        apu_req_i   = 1'b0;
        apu_op_i    = OP_ADD;
        apu_flags_i = '0;
        operands[0] = '0;
        operands[1] = '0;
        operands[2] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (apu_rvalid_o !== 1'b0) begin bad++; $display("FAIL reset_rvalid: got %b want 0", apu_rvalid_o); end
        total++; if (apu_result_o !== 32'd0) begin bad++; $display("FAIL reset_result: got %h want 0", apu_result_o); end
        total++; if (apu_rflags_o !== 5'd0) begin bad++; $display("FAIL reset_rflags: got %h want 0", apu_rflags_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (busy_o !== 1'b0 || apu_rvalid_o !== 1'b0) begin
            bad++; $display("FAIL post_reset_idle: busy=%b rvalid=%b want 0/0", busy_o, apu_rvalid_o);
        end
        @(posedge clk);
        #1;
        obs_q.delete();
    endtask

    task automatic test_back_to_back();
        int x1, x2;
        send(OP_ADD, 32'd5, 32'd7, 32'd12, 5'd0, PIPE, x1);
        send(OP_SUB, 32'd3, 32'd5, 32'hFFFF_FFFE, 5'd0, PIPE, x2);
        total++; if (x2 !== x1 + 1) begin bad++; $display("FAIL b2b_grant: second transfer at %0d want %0d", x2, x1 + 1); end
        drain();
        total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL b2b_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL b2b[%0d]: got cyc=%0d res=%h flg=%h want cyc=%0d res=%h flg=%h", i,
                         obs_q[i].cyc, obs_q[i].res, obs_q[i].flg, exp_q[i].cyc, exp_q[i].res, exp_q[i].flg);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_illegal();
        int x;
        send(6'h3F, 32'd123, 32'd456, 32'd0, 5'b00010, PIPE, x);
`ifndef CV32E40P_APU_RESP_DIV_EN
        send(OP_DIVU, 32'd8, 32'd2, 32'd0, 5'b00010, PIPE, x);
        send(OP_REM, 32'd9, 32'd4, 32'd0, 5'b00010, PIPE, x);
`endif
        send(6'd10, 32'd1, 32'd1, 32'd0, 5'b00010, PIPE, x);
        drain();
        total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL illegal_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL illegal[%0d]: got cyc=%0d res=%h flg=%h want cyc=%0d res=%h flg=%h", i,
                         obs_q[i].cyc, obs_q[i].res, obs_q[i].flg, exp_q[i].cyc, exp_q[i].res, exp_q[i].flg);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        logic [31:0] a, b, res;
        logic [31:0] specials [4];
        logic [4:0]  flg;
        logic [5:0]  op;
        int          lat, x, r;
        specials[0] = 32'd0; specials[1] = 32'd1; specials[2] = 32'hFFFF_FFFF; specials[3] = 32'h8000_0000;
        for (int n = 0; n < 60; n++) begin
            r = int'($urandom_range(0, 19));
            if (r < 12)      op = 6'(r % 6);
            else if (r < 16) op = 6'(6 + r - 12);
            else             op = 6'($urandom_range(10, 63));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) a = specials[$urandom_range(0, 3)];
            if ($urandom_range(0, 3) == 0) b = specials[$urandom_range(0, 3)];
            ref_model(op, a, b, res, flg, lat);
            send(op, a, b, res, flg, lat, x);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        drain();
        total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL random_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL random[%0d]: got cyc=%0d res=%h flg=%h want cyc=%0d res=%h flg=%h", i,
                         obs_q[i].cyc, obs_q[i].res, obs_q[i].flg, exp_q[i].cyc, exp_q[i].res, exp_q[i].flg);
            end
        end
        obs_q.delete(); exp_q.delete();
        total++; if (idle_bad != 0) begin bad++; $display("FAIL idle_outputs_zero: %0d cycles nonzero, want 0", idle_bad); end
    endtask

`ifdef CV32E40P_APU_RESP_DIV_EN
    task automatic test_div_basic();
        int t, x, gnt_hi, busy_lo;
        send(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 5'd0, DIV_LAT, t);
        // Keep an ADD pending across the divide: gnt must stay low t+1..t+33
        apu_req_i = 1'b1; apu_op_i = OP_ADD; operands[0] = 32'd1; operands[1] = 32'd2;
        gnt_hi = 0; busy_lo = 0;
        for (int k = 1; k <= DIV_LAT; k++) begin
            @(negedge clk);
            if (apu_gnt_o !== 1'b0) gnt_hi++;
            if (busy_o !== 1'b1) busy_lo++;
        end
        total++; if (gnt_hi != 0) begin bad++; $display("FAIL div_gnt_low: gnt high %0d cycles want 0", gnt_hi); end
        total++; if (busy_lo != 0) begin bad++; $display("FAIL div_busy: busy low %0d cycles want 0", busy_lo); end
        send(OP_ADD, 32'd1, 32'd2, 32'd3, 5'd0, PIPE, x);
        total++; if (x !== t + DIV_LAT + 1) begin bad++; $display("FAIL div_gnt_return: granted at %0d want %0d", x, t + DIV_LAT + 1); end
        drain();
        send(OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 5'd0, DIV_LAT, x);
        drain();
        total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL div_basic_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL div_basic[%0d]: got cyc=%0d res=%h flg=%h want cyc=%0d res=%h flg=%h", i,
                         obs_q[i].cyc, obs_q[i].res, obs_q[i].flg, exp_q[i].cyc, exp_q[i].res, exp_q[i].flg);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_div_corner();
        int x;
        send(OP_DIVU, 32'd100, 32'd0, 32'hFFFF_FFFF, 5'd1, DIV_LAT, x);
        send(OP_REMU, 32'd100, 32'd0, 32'd100, 5'd1, DIV_LAT, x);
        send(OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 5'd1, DIV_LAT, x);
        send(OP_REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 5'd1, DIV_LAT, x);
        send(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 5'd0, DIV_LAT, x);
        send(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 5'd0, DIV_LAT, x);
        send(OP_DIVU, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555, 5'd0, DIV_LAT, x);
        send(OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 5'd0, DIV_LAT, x);
        drain();
        total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL div_corner_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL div_corner[%0d]: got cyc=%0d res=%h flg=%h want cyc=%0d res=%h flg=%h", i,
                         obs_q[i].cyc, obs_q[i].res, obs_q[i].flg, exp_q[i].cyc, exp_q[i].res, exp_q[i].flg);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_mul_then_div();
        logic [31:0] res;
        logic [4:0]  flg;
        int          lat, xm, xd;
        ref_model(OP_MUL, 32'h1234_5678, 32'h9ABC_DEF0, res, flg, lat);
        send(OP_MUL, 32'h1234_5678, 32'h9ABC_DEF0, res, flg, lat, xm);
        ref_model(OP_DIV, 32'd1000, 32'hFFFF_FFF9, res, flg, lat);
        send(OP_DIV, 32'd1000, 32'hFFFF_FFF9, res, flg, lat, xd);
        total++; if (xd !== xm + 2) begin bad++; $display("FAIL mul_div_gnt: div granted at %0d want %0d", xd, xm + 2); end
        drain();
        total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL mul_div_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL mul_div[%0d]: got cyc=%0d res=%h flg=%h want cyc=%0d res=%h flg=%h", i,
                         obs_q[i].cyc, obs_q[i].res, obs_q[i].flg, exp_q[i].cyc, exp_q[i].res, exp_q[i].flg);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid_div();
        int t, x, rel;
        send(OP_DIV, 32'd1000, 32'd7, 32'd142, 5'd0, DIV_LAT, t);
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        total++; if (apu_rvalid_o !== 1'b0 || apu_result_o !== 32'd0 || apu_rflags_o !== 5'd0 || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_outputs: rvalid=%b res=%h flg=%h busy=%b want all 0",
                     apu_rvalid_o, apu_result_o, apu_rflags_o, busy_o);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rel = int'(cyc);
        obs_q.delete(); exp_q.delete();
        send(OP_ADD, 32'd10, 32'd20, 32'd30, 5'd0, PIPE, x);
        total++; if (x !== rel) begin bad++; $display("FAIL mid_reset_gnt: granted at %0d want %0d", x, rel); end
        repeat (40) @(posedge clk);
        #1;
        total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL mid_reset_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL mid_reset[%0d]: got cyc=%0d res=%h flg=%h want cyc=%0d res=%h flg=%h", i,
                         obs_q[i].cyc, obs_q[i].res, obs_q[i].flg, exp_q[i].cyc, exp_q[i].res, exp_q[i].flg);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask
`endif

    initial begin
        test_reset();
        test_back_to_back();
        test_illegal();
        test_random();
`ifdef CV32E40P_APU_RESP_DIV_EN
        test_div_basic();
        test_div_corner();
        test_mul_then_div();
        test_reset_mid_div();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
